// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, the control
// bundle driven to the pipeline registers, and the default divider latency.
package pipeline_ctrl_pkg;

  localparam int DEFAULT_DIV_LATENCY = 32;
  localparam int DIV_CNT_W           = 6;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_DIV_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_stall;
    logic exmem_flush;
    logic memwb_stall;
    logic div_busy;
    logic div_done;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = ctrl_t'(10'd0);

  // Whole-pipeline freeze used while the data memory is not ready.
  function automatic ctrl_t ctrl_freeze(input ctrl_t base);
    ctrl_t c;
    c             = base;
    c.pc_stall    = 1'b1;
    c.ifid_stall  = 1'b1;
    c.idex_stall  = 1'b1;
    c.exmem_stall = 1'b1;
    c.memwb_stall = 1'b1;
    return c;
  endfunction

  // Hold the front end and the divide in EX while a bubble drains into MEM.
  function automatic ctrl_t ctrl_div_hold(input ctrl_t base);
    ctrl_t c;
    c             = base;
    c.pc_stall    = 1'b1;
    c.ifid_stall  = 1'b1;
    c.idex_stall  = 1'b1;
    c.exmem_flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use hazard detection between the ID and EX stages.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
  // x0 is hardwired to zero, so a load into it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: prioritised stall/flush generation plus a
// multi-cycle divider occupancy FSM that holds the pipeline around EX.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY = DEFAULT_DIV_LATENCY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_branch_taken,
  input  logic       ex_div_start,
  input  logic       imem_busywait,
  input  logic       dmem_busywait,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       ifid_flush,
  output logic       idex_stall,
  output logic       idex_flush,
  output logic       exmem_stall,
  output logic       exmem_flush,
  output logic       memwb_stall,
  output logic       div_busy,
  output logic       div_done
);

  // The start cycle in RUN and the done cycle each consume one EX cycle.
  localparam logic [DIV_CNT_W-1:0] DIV_LOAD = DIV_CNT_W'(DIV_LATENCY - 2);

  state_e               state_q, state_d;
  logic [DIV_CNT_W-1:0] div_cnt_q, div_cnt_d;
  ctrl_t                ctrl;
  logic                 load_use;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  // Next-state, divide counter and prioritised pipeline control.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    ctrl      = CTRL_NONE;
    if (rst) begin
      state_d   = ST_RUN;
      div_cnt_d = {DIV_CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_RUN: begin
          if (dmem_busywait) begin
            ctrl = ctrl_freeze(CTRL_NONE);
          end else if (ex_branch_taken) begin
            // PC takes the target even if the fetch is still pending.
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
          end else if (load_use) begin
            ctrl.pc_stall   = 1'b1;
            ctrl.ifid_stall = 1'b1;
            ctrl.idex_flush = 1'b1;
          end else if (ex_div_start) begin
            ctrl      = ctrl_div_hold(CTRL_NONE);
            state_d   = ST_DIV_WAIT;
            div_cnt_d = DIV_LOAD;
          end else if (imem_busywait) begin
            ctrl.pc_stall   = 1'b1;
            ctrl.ifid_flush = 1'b1;
          end else begin
            ctrl = CTRL_NONE;
          end
        end
        ST_DIV_WAIT: begin
          ctrl.div_busy = 1'b1;
          if (dmem_busywait) begin
            ctrl = ctrl_freeze(ctrl);
          end else if (div_cnt_q != {DIV_CNT_W{1'b0}}) begin
            ctrl      = ctrl_div_hold(ctrl);
            div_cnt_d = div_cnt_q - {{(DIV_CNT_W-1){1'b0}}, 1'b1};
          end else begin
            ctrl.div_done = 1'b1;
            state_d       = ST_RUN;
          end
        end
        default: begin
          state_d   = ST_RUN;
          div_cnt_d = {DIV_CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State and divide counter registers.
  always_ff @(posedge clk) begin
    state_q   <= state_d;
    div_cnt_q <= div_cnt_d;
  end

  assign pc_stall    = ctrl.pc_stall;
  assign ifid_stall  = ctrl.ifid_stall;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_stall  = ctrl.idex_stall;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_stall = ctrl.exmem_stall;
  assign exmem_flush = ctrl.exmem_flush;
  assign memwb_stall = ctrl.memwb_stall;
  assign div_busy    = ctrl.div_busy;
  assign div_done    = ctrl.div_done;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a cycle-level behavioural
// model checked every cycle, plus directed vectors with literal expectations.
module tb_pipeline_hazard_ctrl;

  localparam int LAT = 32;

  // Output vector bit masks, MSB first: pc_stall .. div_done.
  localparam logic [9:0] M_PC    = 10'b10_0000_0000;
  localparam logic [9:0] M_IFS   = 10'b01_0000_0000;
  localparam logic [9:0] M_IFF   = 10'b00_1000_0000;
  localparam logic [9:0] M_IDS   = 10'b00_0100_0000;
  localparam logic [9:0] M_IDF   = 10'b00_0010_0000;
  localparam logic [9:0] M_EXS   = 10'b00_0001_0000;
  localparam logic [9:0] M_EXF   = 10'b00_0000_1000;
  localparam logic [9:0] M_MWS   = 10'b00_0000_0100;
  localparam logic [9:0] M_BUSY  = 10'b00_0000_0010;
  localparam logic [9:0] M_DONE  = 10'b00_0000_0001;
  localparam logic [9:0] M_ALLST = M_PC | M_IFS | M_IDS | M_EXS | M_MWS;
  localparam logic [9:0] M_DIVH  = M_PC | M_IFS | M_IDS | M_EXF;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic       ex_div_start, imem_busywait, dmem_busywait;
  logic       pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic       exmem_stall, exmem_flush, memwb_stall, div_busy, div_done;
  logic [9:0] outs;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign outs = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                 exmem_stall, exmem_flush, memwb_stall, div_busy, div_done};

  pipeline_hazard_ctrl #(.DIV_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .ex_div_start(ex_div_start),
    .imem_busywait(imem_busywait), .dmem_busywait(dmem_busywait),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush),
    .exmem_stall(exmem_stall), .exmem_flush(exmem_flush),
    .memwb_stall(memwb_stall), .div_busy(div_busy), .div_done(div_done)
  );

  task automatic cmp(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic cmp_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [9:0] exp);
    @(negedge clk);
    cmp(name, outs, exp);
  endtask

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; ex_div_start = 1'b0;
    imem_busywait = 1'b0; dmem_busywait = 1'b0;
  endtask

  // Model: divider occupancy is tracked as remaining non-frozen EX cycles.
  task automatic model_loop();
    logic [9:0] e;
    logic       lu, in_div, nxt_in;
    int         rem, nxt_rem;
    in_div = 1'b0;
    rem    = 0;
    forever begin
      @(negedge clk);
      e       = 10'd0;
      nxt_in  = in_div;
      nxt_rem = rem;
      lu = ex_mem_read && (ex_rd != 5'd0) &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      if (rst) begin
        nxt_in  = 1'b0;
        nxt_rem = 0;
      end else if (in_div) begin
        e = M_BUSY;
        if (dmem_busywait) e = e | M_ALLST;
        else if (rem > 1) begin
          e       = e | M_DIVH;
          nxt_rem = rem - 1;
        end else begin
          e      = e | M_DONE;
          nxt_in = 1'b0;
        end
      end else if (dmem_busywait)   e = M_ALLST;
      else if (ex_branch_taken)     e = M_IFF | M_IDF;
      else if (lu)                  e = M_PC | M_IFS | M_IDF;
      else if (ex_div_start) begin
        e       = M_DIVH;
        nxt_in  = 1'b1;
        nxt_rem = LAT - 1;
      end else if (imem_busywait)   e = M_PC | M_IFF;
      cmp("model", outs, e);
      @(posedge clk);
      in_div = nxt_in;
      rem    = nxt_rem;
    end
  endtask

  // One divide; cycle 1 is the start cycle. Optional dmem freeze and reset abort.
  task automatic run_div(input string tag, input int frz_at, input int frz_len,
                         input int rst_at, input int exp_done, input int exp_busy);
    int done_at, busy_n, c;
    ex_div_start = 1'b1;
    chk({tag, "_start"}, M_DIVH);
    step();
    ex_div_start = 1'b0;
    done_at = 0; busy_n = 0; c = 2;
    while (done_at == 0 && c <= 60) begin
      rst             = (c == rst_at);
      dmem_busywait   = (c >= frz_at && c < frz_at + frz_len);
      ex_branch_taken = (c == 5);
      ex_mem_read     = (c == 6);
      id_uses_rs1     = (c == 6);
      ex_rd = 5'd3; id_rs1 = 5'd3;
      @(negedge clk);
      if (div_busy) busy_n++;
      if (div_done) done_at = c;
      if (c == frz_at) cmp({tag, "_freeze"}, outs, M_ALLST | M_BUSY);
      if (c == rst_at) cmp({tag, "_abort"}, outs, 10'd0);
      step();
      c++;
    end
    rst = 1'b0;
    clear_inputs();
    chk({tag, "_after"}, 10'd0);
    step();
    cmp_int({tag, "_done_cycle"}, done_at, exp_done);
    cmp_int({tag, "_busy_cycles"}, busy_n, exp_busy);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    fork
      model_loop();
    join_none

    dmem_busywait = 1'b1; ex_branch_taken = 1'b1; ex_div_start = 1'b1;
    chk("reset", 10'd0);
    step(); step();
    rst = 1'b0;
    clear_inputs();
    chk("idle", 10'd0);
    step();

    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    chk("lu_rs1", M_PC | M_IFS | M_IDF);
    step();
    clear_inputs();
    chk("lu_bubble_done", 10'd0);
    step();

    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    chk("lu_rd0", 10'd0);
    step();

    clear_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    chk("lu_rs2", M_PC | M_IFS | M_IDF);
    step();

    clear_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b0;
    chk("lu_unused", 10'd0);
    step();

    clear_inputs();
    ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
    chk("no_load", 10'd0);
    step();

    clear_inputs();
    ex_branch_taken = 1'b1; imem_busywait = 1'b1;
    chk("branch_imem", M_IFF | M_IDF);
    step();

    clear_inputs();
    imem_busywait = 1'b1;
    chk("imem", M_PC | M_IFF);
    step();

    clear_inputs();
    dmem_busywait = 1'b1; ex_branch_taken = 1'b1;
    chk("dmem_branch", M_ALLST);
    step();

    clear_inputs();
    ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs2 = 5'd4; id_uses_rs2 = 1'b1;
    chk("branch_over_lu", M_IFF | M_IDF);
    step();

    ex_branch_taken = 1'b0; ex_div_start = 1'b1;
    chk("lu_over_div", M_PC | M_IFS | M_IDF);
    step();

    clear_inputs();
    dmem_busywait = 1'b1; ex_div_start = 1'b1;
    chk("dmem_over_div", M_ALLST);
    step();
    clear_inputs();
    chk("div_not_entered", 10'd0);
    step();

    run_div("div", 0, 0, 0, LAT, LAT - 1);
    run_div("div_frz", 22, 3, 0, LAT + 3, LAT + 2);
    run_div("div_rst", 0, 0, 17, 0, 15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
